// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers for the E stage of a five-stage MIPS pipeline.
// Results are computed at accept time and committed after a fixed busy latency.
module mdu_hilo #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        move_to,
  input  logic [2:0]  sel,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic [31:0]      w_pend_hi_nxt;
  logic [31:0]      w_pend_lo_nxt;
  logic             r_pend_wr;
  logic             w_pend_wr_nxt;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_div_bs;
  logic [31:0] w_div_bu;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;

  function automatic logic [31:0] f_neg(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  function automatic logic [31:0] f_abs(input logic [31:0] v);
    return v[31] ? f_neg(v) : v;
  endfunction

  // Sign-extending both operands to 64 bits makes the low half of the product the signed result.
  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division runs on magnitudes; a zero divisor is replaced so the divider never sees it.
  assign w_div_zero = (rt_val == 32'd0);
  assign w_neg_a    = rs_val[31];
  assign w_neg_b    = rt_val[31];
  assign w_abs_a    = f_abs(rs_val);
  assign w_abs_b    = f_abs(rt_val);
  assign w_div_bs   = w_div_zero ? 32'd1 : w_abs_b;
  assign w_div_bu   = w_div_zero ? 32'd1 : rt_val;
  assign w_mag_q    = w_abs_a / w_div_bs;
  assign w_mag_r    = w_abs_a % w_div_bs;
  assign w_quo_s    = (w_neg_a ^ w_neg_b) ? f_neg(w_mag_q) : w_mag_q;
  assign w_rem_s    = w_neg_a ? f_neg(w_mag_r) : w_mag_r;
  assign w_quo_u    = rs_val / w_div_bu;
  assign w_rem_u    = rs_val % w_div_bu;

  // Next-state, counter, pending-result and HI/LO update logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_wr_nxt = r_pend_wr;
    case (r_state)
      ST_IDLE: begin
        if (!cancel && start) begin
          case (sel)
            3'd0: begin
              w_pend_hi_nxt = w_prod_s[63:32];
              w_pend_lo_nxt = w_prod_s[31:0];
              w_pend_wr_nxt = 1'b1;
              w_cnt_nxt     = CNT_W'(MUL_CYCLES);
              w_state_nxt   = ST_BUSY;
            end
            3'd1: begin
              w_pend_hi_nxt = w_prod_u[63:32];
              w_pend_lo_nxt = w_prod_u[31:0];
              w_pend_wr_nxt = 1'b1;
              w_cnt_nxt     = CNT_W'(MUL_CYCLES);
              w_state_nxt   = ST_BUSY;
            end
            3'd2: begin
              w_pend_hi_nxt = w_rem_s;
              w_pend_lo_nxt = w_quo_s;
              w_pend_wr_nxt = ~w_div_zero;
              w_cnt_nxt     = CNT_W'(DIV_CYCLES);
              w_state_nxt   = ST_BUSY;
            end
            3'd3: begin
              w_pend_hi_nxt = w_rem_u;
              w_pend_lo_nxt = w_quo_u;
              w_pend_wr_nxt = ~w_div_zero;
              w_cnt_nxt     = CNT_W'(DIV_CYCLES);
              w_state_nxt   = ST_BUSY;
            end
            default: begin
            end
          endcase
        end else if (!cancel && move_to) begin
          case (sel)
            3'd4:    w_hi_nxt = rs_val;
            3'd5:    w_lo_nxt = rs_val;
            default: begin
            end
          endcase
        end else begin
        end
      end
      ST_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          if (r_pend_wr) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end else begin
          end
          w_pend_wr_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_wr <= w_pend_wr_nxt;
    end
  end

  assign busy    = (r_state == ST_BUSY);
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rd_data = (sel == 3'd4) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed literal cases plus randomized traffic against a cycle-indexed model.
module tb_mdu_hilo;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        move_to = 1'b0;
  logic [2:0]  sel = 3'd7;
  logic        cancel = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  mdu_hilo #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .move_to(move_to), .sel(sel),
    .cancel(cancel), .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
    .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: absolute edge number at which the in-flight result lands.
  int          edge_n = 0;
  bit          chk_en = 1'b0;
  bit          m_infl = 1'b0;
  int          m_end = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [64:0] m_res = 65'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Returns {write_enable, hi, lo} for an arithmetic operation.
  function automatic logic [64:0] f_result(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    longint          p, q, r;
    longint unsigned pu;
    logic [31:0]     uq, ur;
    case (s)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return {1'b1, p[63:0]};
      end
      3'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        return {1'b1, pu[63:0]};
      end
      3'd2: begin
        if (b == 32'd0) return 65'd0;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {1'b1, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return 65'd0;
        uq = a / b;
        ur = a % b;
        return {1'b1, ur, uq};
      end
      default: return 65'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_infl <= 1'b0;
      m_res  <= 65'd0;
      chk_en <= 1'b1;
    end else if (m_infl) begin
      if (edge_n + 1 == m_end) begin
        m_infl <= 1'b0;
        if (m_res[64]) begin
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
        end
      end
    end else if (!cancel && start) begin
      if (sel <= 3'd3) begin
        m_res  <= f_result(sel, rs_val, rt_val);
        m_infl <= 1'b1;
        m_end  <= edge_n + 1 + ((sel <= 3'd1) ? MUL_N : DIV_N);
      end
    end else if (!cancel && move_to) begin
      if (sel == 3'd4) m_hi <= rs_val;
      else if (sel == 3'd5) m_lo <= rs_val;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_infl});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("rd_data", rd_data, (sel == 3'd4) ? m_hi : m_lo);
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b1 && busy === 1'b1 && (start || move_to))
      $error("protocol violation: start/move_to issued while busy");
  end

  task automatic drive(input bit st, input bit mv, input logic [2:0] s, input bit c,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    start = st; move_to = mv; sel = s; cancel = c; rs_val = a; rt_val = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd7, 1'b0, 32'd0, 32'd0);
  endtask

  // Counts busy cycles, stopping at the first idle sample or after a fixed bound.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
  endtask

  task automatic op(input string name, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                    input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    drive(1'b1, 1'b0, s, 1'b0, a, b);
    idle();
    count_busy(n);
    check({name, "_cycles"}, 32'(n), 32'(exp_n));
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    op("mult", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, MUL_N, 32'h0000_0001, 32'hFFFF_FFFE);
    op("div", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op("divu", 3'd3, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);

    drive(1'b0, 1'b1, 3'd4, 1'b0, 32'h1234_5678, 32'd0);
    drive(1'b0, 1'b1, 3'd5, 1'b0, 32'h9ABC_DEF0, 32'd0);
    drive(1'b0, 1'b0, 3'd4, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_rd", rd_data, 32'h1234_5678);
    check("mt_busy", {31'd0, busy}, 32'd0);
    drive(1'b0, 1'b0, 3'd5, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("mtlo_rd", rd_data, 32'h9ABC_DEF0);
    check("mthi_hi", hi, 32'h1234_5678);

    drive(1'b0, 1'b1, 3'd4, 1'b0, 32'h0000_00AA, 32'd0);
    drive(1'b0, 1'b1, 3'd5, 1'b0, 32'h0000_00BB, 32'd0);
    op("divu_by0", 3'd3, 32'd5, 32'd0, DIV_N, 32'h0000_00AA, 32'h0000_00BB);

    drive(1'b1, 1'b0, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'd2);
    idle();
    repeat (3) @(negedge clk);
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h0000_00AA);
    check("cancel_lo", lo, 32'h0000_00BB);

    drive(1'b1, 1'b0, 3'd1, 1'b0, 32'd3, 32'd4);
    drive(1'b0, 1'b0, 3'd7, 1'b1, 32'd0, 32'd0);
    count_busy(n);
    check("late_cancel_cycles", 32'(n), 32'(MUL_N));
    check("late_cancel_hi", hi, 32'd0);
    check("late_cancel_lo", lo, 32'd12);

    op("div_min", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);

    drive(1'b1, 1'b0, 3'd0, 1'b0, 32'd3, 32'd5);
    idle();
    @(posedge clk);
    #2;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (10) @(negedge clk);
    check("abort_nocommit_lo", lo, 32'd0);

    // Randomized traffic; new operations only when the model says the unit is idle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      reset   = ($urandom_range(0, 99) != 0);
      cancel  = ($urandom_range(0, 6) == 0);
      sel     = 3'($urandom_range(0, 7));
      rs_val  = pick();
      rt_val  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      if (m_infl) begin
        start   = 1'b0;
        move_to = 1'b0;
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2: begin start = 1'b1; move_to = 1'b0; end
          3, 4:    begin start = 1'b0; move_to = 1'b1; end
          5:       begin start = 1'b1; move_to = 1'b1; end
          default: begin start = 1'b0; move_to = 1'b0; end
        endcase
      end
    end
    reset = 1'b1;
    idle();
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers in the E stage of the five-stage MIPS pipeline.
- Executes the control bundle the instruction decoder produces for mult/multu/div/divu/mfhi/mflo/mthi/mtlo: start, move-to and a 3-bit operation select.
- Models multi-cycle latency with a busy flag; the hazard unit stalls D-stage MDU instructions on (start | busy).
- Supplies HI/LO read data to the E→M pipeline register for mfhi/mflo.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising edge clears all state.
- start  input  1  E-stage instruction is mult/multu/div/divu.
- move_to  input  1  E-stage instruction is mthi/mtlo.
- sel  input  3  operation select: 0=MUL, 1=MULU, 2=DIV, 3=DIVU, 4=SELECT_HI, 5=SELECT_LO, 7=none.
- cancel  input  1  E-stage instruction is being flushed (exception/interrupt); suppresses start/move_to this cycle.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo data).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- rd_data  output  32  combinational: hi when sel==4, else lo.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result cleared.
- States: IDLE, BUSY. busy is 1 exactly in BUSY (registered, not combinational from start).
- Accept condition: IDLE & ~cancel.
- start accepted at edge T:
  - Compute the full result from rs_val/rt_val/sel into 64-bit pending registers.
  - Load counter = MUL_CYCLES (sel 0/1) or DIV_CYCLES (sel 2/3); go to BUSY.
  - start with sel outside 0..3: ignored.
- BUSY: counter decrements each edge. At the edge where counter==1: commit pending to {hi,lo}, return to IDLE, busy=0.
  - busy is therefore high for exactly N cycles after T; new hi/lo are visible in the cycle busy first reads 0.
- Arithmetic:
  - mult: signed 32×32→64, {hi,lo}=product.
  - multu: unsigned 32×32→64.
  - div: signed, quotient truncated toward zero; lo=quotient, hi=remainder (sign of dividend).
  - divu: unsigned; lo=quotient, hi=remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor==0 (div/divu): full DIV_CYCLES busy, hi/lo unchanged at commit.
- move_to accepted:
  - sel==4 → hi<=rs_val; sel==5 → lo<=rs_val; takes effect next edge; no busy.
  - Other sel: ignored.
- start and move_to in the same cycle: start wins, move_to dropped.
- start or move_to while BUSY: ignored; the stall logic prevents this, and an assertion in the bench flags it.
- cancel while BUSY: no effect; the in-flight operation completes and commits.
- cancel with start/move_to in IDLE: nothing changes.
- reset low mid-operation: abort; hi/lo cleared; pending result discarded.
- rd_data reads the committed hi/lo only; no bypass of pending results.

Test Plan:
- Reset, then mult rs=0xFFFFFFFF rt=0x00000002 → busy=1 for 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (−7) rt=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 → lo=3, hi=1.
- mthi 0x12345678, next cycle mtlo 0x9ABCDEF0 → hi/lo updated one edge later, busy never set; rd_data follows sel (4→0x12345678, 5→0x9ABCDEF0).
- divu rs=5 rt=0 with prior hi=0xAA, lo=0xBB → busy 10 cycles, hi=0xAA, lo=0xBB after.
- start+cancel in the same cycle → busy stays 0, hi/lo unchanged. start then cancel on the next cycle → operation completes and commits.
- mult started, reset low on the 3rd busy cycle → next edge busy=0, hi=lo=0, no later commit.
